pipe_hold_ctrl: RTL

Central producer of the pipeline hold/flush command that the pc, if_id and id_ex stage registers consume.
- Merges stall requests from ex (jump, multi-cycle ops), the bus arbiter, clint and the debug halt into one priority-encoded hold_flag_o.
- Stretches jump flushes over a programmable number of cycles and watchdogs stuck bus stalls.
- Counts stalled cycles for performance monitoring.

---
 rtl/pipe_hold_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges stall sources into one Hold_Flag_Bus command,
// stretches jump flushes, watchdogs stuck bus stalls and counts stalled cycles.
module pipe_hold_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned BUS_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_ex_i,
    input  logic             hold_rib_i,
    input  logic             hold_clint_i,
    input  logic             halt_i,
    output logic [2:0]       hold_flag_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             bus_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam logic [2:0]  HOLD_NONE = 3'd0;
    localparam logic [2:0]  HOLD_PC   = 3'd1;
    localparam logic [2:0]  HOLD_ID   = 3'd3;
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [15:0] TMO_LIMIT  = 16'(BUS_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FLUSH   = 2'd1,
        S_BUSWAIT = 2'd2,
        S_HALT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;
    logic             rib_mask_q, rib_mask_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout;
    logic [2:0]       hold_raw;
    state_e           jump_target;

    // With no extra flush cycles a jump needs only its own cycle of Hold_Id.
    assign jump_target = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rib_mask_d  = rib_mask_q & hold_rib_i;
        timeout     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (jump_flag_i) begin
                    state_d     = jump_target;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (hold_rib_i && !rib_mask_q) begin
                    state_d   = S_BUSWAIT;
                    tmo_cnt_d = 16'd1;
                end
            end
            S_FLUSH: begin
                if (halt_i) begin
                    state_d     = S_HALT;
                    flush_cnt_d = 4'd0;
                end else if (jump_flag_i) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == 4'd1) begin
                    state_d     = S_IDLE;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            S_BUSWAIT: begin
                tmo_cnt_d = 16'd0;
                if (halt_i) begin
                    state_d = S_HALT;
                end else if (jump_flag_i) begin
                    state_d     = jump_target;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (!hold_rib_i) begin
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    timeout    = 1'b1;
                    rib_mask_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_HALT: begin
                if (!halt_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hold_raw = HOLD_NONE;
        if (jump_flag_i || hold_ex_i || hold_clint_i || state_q == S_FLUSH ||
            (state_q == S_HALT && halt_i)) begin
            hold_raw = HOLD_ID;
        end else if (hold_rib_i && !rib_mask_q) begin
            hold_raw = HOLD_PC;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold_raw != HOLD_NONE && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every register here uses <=; the _d values above are pure combinational next-state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= 4'd0;
            tmo_cnt_q   <= 16'd0;
            rib_mask_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rib_mask_q  <= rib_mask_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced low during reset, not only the registered ones.
    assign hold_flag_o   = rst ? hold_raw : HOLD_NONE;
    assign jump_flag_o   = rst & jump_flag_i & (state_q != S_HALT);
    assign jump_addr_o   = jump_flag_o ? jump_addr_i : 32'd0;
    assign bus_timeout_o = rst & timeout;
    assign stall_cnt_o   = stall_cnt_q;
    assign state_o       = state_q;

endmodule
